// File: rtl/norm_pkg.sv
// Shared types and constants for the running-norm datapath.
// The norm sample type is also used by the upstream accumulator/sqrt stage.
package norm_pkg;

  localparam int NORM_W          = 10;
  localparam int NORM_FIFO_DEPTH = 8;

  typedef logic [NORM_W-1:0] norm_t;

endpackage

// File: rtl/norm_fifo_ram.sv
// FIFO storage for norm_out_fifo: DEPTH x DATA_W array with one synchronous
// write port and one asynchronous (combinational) read port. No reset on
// storage; only the control state in the top module is reset.
module norm_fifo_ram #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 10
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Capture the incoming sample at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/norm_out_fifo.sv
// Output buffer of the running-norm datapath. Captures each norm sample
// offered by the upstream stage, buffers it in a show-ahead FIFO and hands it
// to a consumer over valid/ready. The upstream cannot be stalled, so samples
// arriving while the FIFO is full are dropped, flagged (sticky overflow) and
// counted in a saturating drop counter.
// Optional build macro NORM_PEAK_EN adds a running peak of accepted samples
// (output peak, input clr_peak).
module norm_out_fifo
  import norm_pkg::*;
#(
  parameter int DEPTH  = NORM_FIFO_DEPTH,
  parameter int DATA_W = NORM_W,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
`ifdef NORM_PEAK_EN
  output logic [DATA_W-1:0]        peak,
  input  logic                     clr_peak,
`endif
  input  logic                     clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);

  // A full FIFO still accepts a sample when the head leaves the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  norm_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  // Read/write pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Occupancy: unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and drop counter; a drop in the clearing cycle counts as 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef NORM_PEAK_EN
  function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Running peak over accepted samples only; a clear restarts from the push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak <= '0;
    end else if (push) begin
      peak <= clr_peak ? in_data : max_of(peak, in_data);
    end else if (clr_peak) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_norm_out_fifo.sv
// Directed self-checking bench for norm_out_fifo (DEPTH=8, DATA_W=10, DROP_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_norm_out_fifo;

  logic       clk;
  logic       reset;
  logic [9:0] in_data;
  logic       in_valid;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_ovf;
`ifdef NORM_PEAK_EN
  logic [9:0] peak;
  logic       clr_peak;
`endif

  int tests_run;
  int tests_failed;

  norm_out_fifo #(.DEPTH(8), .DATA_W(10), .DROP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
`ifdef NORM_PEAK_EN
    .peak      (peak),
    .clr_peak  (clr_peak),
`endif
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Push n samples start, start+1, ... with the consumer stalled.
  task automatic fill(input int start, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 10'(start + i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || out_valid !== 1'b0 || full !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_init: count=%0d ov=%0b full=%0b ovf=%0b drop=%0d, required all 0",
               count, out_valid, full, overflow, drop_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    fill(100, 3);
    tests_run++;
    if (count !== 4'd3) begin
      tests_failed++;
      $display("FAIL reset_prefill: count=%0d required 3", count);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: count=%0d ov=%0b ovf=%0b required 0 0 0",
               count, out_valid, overflow);
    end
    #1 reset = 1'b1;
    cyc();
  endtask

  task automatic test_fall_through();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 10'd21;
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 10'd21 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL fall_through_head: ov=%0b data=%0d count=%0d required 1 21 1",
               out_valid, out_data, count);
    end
    cyc();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL fall_through_drain: ov=%0b count=%0d required 0 0", out_valid, count);
    end
    // Empty with ready high: nothing pops, pointers hold.
    cyc();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL empty_ready: ov=%0b count=%0d required 0 0", out_valid, count);
    end
  endtask

  task automatic test_order_wrap();
    fill(1, 8);
    tests_run++;
    if (full !== 1'b1 || count !== 4'd8 || out_data !== 10'd1) begin
      tests_failed++;
      $display("FAIL wrap_full: full=%0b count=%0d head=%0d required 1 8 1",
               full, count, out_data);
    end
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      tests_run++;
      if (out_data !== 10'(i - 8) || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_head_%0d: data=%0d ov=%0b required %0d 1",
                 i, out_data, out_valid, i - 8);
      end
      in_valid = 1'b1;
      in_data  = 10'(i);
      cyc();
      tests_run++;
      if (count !== 4'd8 || full !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_count_%0d: count=%0d full=%0b required 8 1", i, count, full);
      end
    end
    in_valid = 1'b0;
    for (int i = 5; i <= 12; i++) begin
      tests_run++;
      if (out_data !== 10'(i) || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_drain_%0d: data=%0d ov=%0b required %0d 1",
                 i, out_data, out_valid, i);
      end
      cyc();
    end
    tests_run++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_empty: count=%0d ov=%0b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_overflow();
    fill(50, 8);
    tests_run++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL ovf_pre: ovf=%0b drop=%0d required 0 0", overflow, drop_cnt);
    end
    in_valid = 1'b1;
    in_data  = 10'd999;
    repeat (3) cyc();
    tests_run++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd3 || count !== 4'd8 || out_data !== 10'd50) begin
      tests_failed++;
      $display("FAIL ovf_drop3: ovf=%0b drop=%0d count=%0d head=%0d required 1 3 8 50",
               overflow, drop_cnt, count, out_data);
    end
    clr_ovf = 1'b1;
    cyc();
    tests_run++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL ovf_clr_with_drop: ovf=%0b drop=%0d required 1 1", overflow, drop_cnt);
    end
    in_valid = 1'b0;
    cyc();
    clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL ovf_clr_alone: ovf=%0b drop=%0d required 0 0", overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int i = 50; i <= 57; i++) begin
      tests_run++;
      if (out_data !== 10'(i)) begin
        tests_failed++;
        $display("FAIL ovf_contents_%0d: data=%0d required %0d", i, out_data, i);
      end
      cyc();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    fill(200, 8);
    in_valid = 1'b1;
    in_data  = 10'd3;
    repeat (255) cyc();
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_reach: drop=%0d required 255", drop_cnt);
    end
    repeat (45) cyc();
    in_valid = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 4'd8) begin
      tests_failed++;
      $display("FAIL sat_hold: drop=%0d ovf=%0b count=%0d required 255 1 8",
               drop_cnt, overflow, count);
    end
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    cyc();
  endtask

`ifdef NORM_PEAK_EN
  task automatic test_peak();
    tests_run++;
    if (peak !== 10'd0) begin
      tests_failed++;
      $display("FAIL peak_reset: peak=%0d required 0", peak);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 10'd41; cyc();
    in_data = 10'd76; cyc();
    in_data = 10'd21; cyc();
    tests_run++;
    if (peak !== 10'd76) begin
      tests_failed++;
      $display("FAIL peak_max: peak=%0d required 76", peak);
    end
    clr_peak = 1'b1;
    in_data  = 10'd5;
    cyc();
    clr_peak = 1'b0;
    tests_run++;
    if (peak !== 10'd5) begin
      tests_failed++;
      $display("FAIL peak_clr_push: peak=%0d required 5", peak);
    end
    fill(1, 4);
    in_valid = 1'b1;
    in_data  = 10'd900;
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if (peak !== 10'd5 || drop_cnt !== 8'd1 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL peak_drop: peak=%0d drop=%0d full=%0b required 5 1 1",
               peak, drop_cnt, full);
    end
    clr_peak = 1'b1;
    cyc();
    clr_peak = 1'b0;
    tests_run++;
    if (peak !== 10'd0) begin
      tests_failed++;
      $display("FAIL peak_clr_alone: peak=%0d required 0", peak);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    clr_ovf      = 1'b0;
`ifdef NORM_PEAK_EN
    clr_peak     = 1'b0;
`endif
    test_reset();
    test_fall_through();
    test_order_wrap();
    test_overflow();
    test_saturation();
`ifdef NORM_PEAK_EN
    test_peak();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
